// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer for a multi-cycle data RAM in a 5-stage MIPS32 pipeline.
// Issues the RAM request. Freezes upstream stages while the RAM is busy. Steers the
// MEM/WB buffer so that WB sees NOPs during waits and real data on completion.
// Optional feature: define MEM_CTRL_TIMEOUT_EN to enable the WAIT-state watchdog abort.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   MemRead_EX_MEM      load in MEM stage
//   MemWrite_EX_MEM     store in MEM stage
//   ram_ready           data RAM has completed the current access
//   ram_req / ram_we    RAM strobe and direction (1 = write)
//   stall_pipe          hold PC, IF/ID, ID/EX and EX/MEM
//   mem_wb_en           MEM/WB loads on this edge
//   mem_wb_bubble       MEM/WB loads a NOP
//   busy                FSM is in WAIT
//   proto_err           sticky: read and write both set at access start
//   timeout_err         sticky: an access was aborted by the watchdog
module mem_stage_ctrl #(
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned MIN_WAIT       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MemRead_EX_MEM,
  input  logic MemWrite_EX_MEM,
  input  logic ram_ready,
  output logic ram_req,
  output logic ram_we,
  output logic stall_pipe,
  output logic mem_wb_en,
  output logic mem_wb_bubble,
  output logic busy,
  output logic proto_err,
  output logic timeout_err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_we;
  logic               w_we_nxt;
  logic               r_proto_err;
  logic               w_proto_set;
  logic               r_timeout_err;
  logic               w_timeout_set;
  logic               w_op;
  logic               w_ready_ok;

  logic w_ram_req, w_ram_we, w_stall, w_wb_en, w_bubble, w_busy;

  assign w_op       = MemRead_EX_MEM | MemWrite_EX_MEM;
  assign w_ready_ok = ram_ready && ((MIN_WAIT == 0) || (r_wait_cnt >= CNT_W'(MIN_WAIT)));

  // State, wait counter, latched direction and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_we          <= 1'b0;
      r_proto_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_cnt_nxt;
      r_we          <= w_we_nxt;
      r_proto_err   <= r_proto_err | w_proto_set;
      r_timeout_err <= r_timeout_err | w_timeout_set;
    end
  end

  // Next-state and combinational outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_wait_cnt;
    w_we_nxt      = r_we;
    w_proto_set   = 1'b0;
    w_timeout_set = 1'b0;
    w_ram_req     = 1'b0;
    w_ram_we      = 1'b0;
    w_stall       = 1'b0;
    w_wb_en       = 1'b1;
    w_bubble      = 1'b0;
    w_busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_op) begin
          // Simultaneous read+write is treated as a write
          w_ram_req   = 1'b1;
          w_ram_we    = MemWrite_EX_MEM;
          w_we_nxt    = MemWrite_EX_MEM;
          w_proto_set = MemRead_EX_MEM & MemWrite_EX_MEM;
          if (w_ready_ok) begin
            // Zero-wait completion: RAM answered in the request cycle
            w_cnt_nxt = '0;
          end else begin
            w_stall     = 1'b1;
            w_bubble    = 1'b1;
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        w_ram_req = 1'b1;
        w_ram_we  = r_we;
        w_stall   = 1'b1;
        w_bubble  = 1'b1;
        w_busy    = 1'b1;
        w_cnt_nxt = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
        if (w_ready_ok) begin
          w_stall     = 1'b0;
          w_bubble    = 1'b0;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
`ifdef MEM_CTRL_TIMEOUT_EN
        else if (!ram_ready && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES))) begin
          // Watchdog abort: release the pipe, discard the result as a bubble
          w_stall       = 1'b0;
          w_timeout_set = 1'b1;
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifndef MEM_CTRL_TIMEOUT_EN
  logic w_unused_timeout;
  assign w_unused_timeout = ^CNT_W'(TIMEOUT_CYCLES);
`endif

  // Outputs are forced low while reset is asserted, independent of the clock
  assign ram_req       = rst_n & w_ram_req;
  assign ram_we        = rst_n & w_ram_we;
  assign stall_pipe    = rst_n & w_stall;
  assign mem_wb_en     = rst_n & w_wb_en;
  assign mem_wb_bubble = rst_n & w_bubble;
  assign busy          = rst_n & w_busy;
  assign proto_err     = r_proto_err;
  assign timeout_err   = r_timeout_err;

endmodule
